lc3_mem_arbiter: RTL

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single LC-3 memory port; data wins ties unless LC3_ARB_RR_EN alternates them.
// Latency: ack WAIT_CYCLES+1 clocks after the IDLE sampling edge; one transaction per WAIT_CYCLES+3 cycles at best.
// Backpressure: requests are levels held until ack; anything not granted simply waits in IDLE.
module lc3_mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        f_req_i,
    input  logic [15:0] f_addr_i,
    output logic        f_ack_o,
    output logic [15:0] f_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [15:0] d_addr_i,
    input  logic [15:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [15:0] d_rdata_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] f_rdata_q, f_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        pick_data;

`ifdef LC3_ARB_RR_EN
    // rr_q set means data wins the next contested grant
    logic rr_q, rr_d;

    always_comb begin
        pick_data = d_req_i && (!f_req_i || rr_q);
        rr_d      = rr_q;
        if (state_q == IDLE && f_req_i && d_req_i) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        pick_data = d_req_i;
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (f_req_i || d_req_i) begin
                    owner_d = pick_data;
                    we_d    = pick_data && d_we_i;
                    addr_d  = pick_data ? d_addr_i : f_addr_i;
                    wdata_d = pick_data ? d_wdata_i : wdata_q;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata_i;
                        end else begin
                            f_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            f_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == ACCESS);
    assign mem_we_o    = (state_q == ACCESS) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign f_ack_o     = (state_q == DONE) && !owner_q;
    assign d_ack_o     = (state_q == DONE) && owner_q;
    assign f_rdata_o   = f_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

endmodule
